// File: rtl/subleq_io_port_pkg.sv
// Types shared by the SUBLEQ I/O port; the state enum reuses the encodings from defines.vh.
`include "defines.vh"

package subleq_io_port_pkg;

    typedef enum logic {
        IO_ST_IDLE = `IO_IDLE,
        IO_ST_ACK  = `IO_ACK
    } io_state_t;

endpackage

// File: rtl/subleq_io_port_if.sv
// CPU-side 4-phase handshakes plus host-side rx/tx streams of the SUBLEQ I/O port.
interface subleq_io_port_if #(
    parameter int WIDTH = 16
);
    logic             in_req;
    logic             in_ack;
    logic [WIDTH-1:0] io_in;
    logic             eof;
    logic             out_req;
    logic             out_ack;
    logic [WIDTH-1:0] io_out;
    logic             rx_valid;
    logic             rx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_end;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] tx_data;

    // The port itself.
    modport slave (
        input  in_req, out_req, io_out, rx_valid, rx_data, rx_end, tx_ready,
        output in_ack, io_in, eof, out_ack, rx_ready, tx_valid, tx_data
    );

    // Decoder plus host environment driving the port.
    modport master (
        output in_req, out_req, io_out, rx_valid, rx_data, rx_end, tx_ready,
        input  in_ack, io_in, eof, out_ack, rx_ready, tx_valid, tx_data
    );
endinterface

// File: rtl/defines.vh
// Shared word size and the state encodings used by both handshake FSMs of the I/O port.
`ifndef SUBLEQ_DEFINES_VH
`define SUBLEQ_DEFINES_VH

`define WORD_SIZE 16

`define IO_IDLE 1'b0
`define IO_ACK  1'b1

`endif

// File: rtl/subleq_io_fifo.sv
// Synchronous FIFO with registered count; no bypass, so a pushed word is visible next cycle.
module subleq_io_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; emptiness comes from count, so stale words are never read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/subleq_io_port.sv
// SUBLEQ MMIO I/O responder: rx/tx FIFOs behind 4-phase CPU handshakes, plus eof generation.
// Optional SUBLEQ_IO_STATS_EN adds rd_count/wr_count handshake counters.
`include "defines.vh"

module subleq_io_port
    import subleq_io_port_pkg::*;
#(
    parameter int WIDTH = `WORD_SIZE,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    subleq_io_port_if.slave   bus
`ifdef SUBLEQ_IO_STATS_EN
    ,
    output logic [WIDTH-1:0]  rd_count,
    output logic [WIDTH-1:0]  wr_count
`endif
);
    io_state_t        in_state, in_next;
    io_state_t        out_state, out_next;
    logic             rx_pop, rx_full, rx_empty;
    logic             tx_push, tx_pop, tx_full, tx_empty;
    logic [WIDTH-1:0] rx_head;
    logic [WIDTH-1:0] io_in_q;
    logic             eof_seen;

    subleq_io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (bus.rx_valid && !rx_full),
        .push_data (bus.rx_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    subleq_io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tx_push),
        .push_data (bus.io_out),
        .pop       (tx_pop),
        .head      (bus.tx_data),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        in_next = in_state;
        rx_pop  = 1'b0;
        case (in_state)
            IO_ST_IDLE: if (bus.in_req && !rx_empty) begin
                rx_pop  = 1'b1;
                in_next = IO_ST_ACK;
            end
            IO_ST_ACK:  if (!bus.in_req) in_next = IO_ST_IDLE;
            default:    in_next = IO_ST_IDLE;
        endcase
    end

    always_comb begin
        out_next = out_state;
        tx_push  = 1'b0;
        case (out_state)
            IO_ST_IDLE: if (bus.out_req && !tx_full) begin
                tx_push  = 1'b1;
                out_next = IO_ST_ACK;
            end
            IO_ST_ACK:  if (!bus.out_req) out_next = IO_ST_IDLE;
            default:    out_next = IO_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_state  <= IO_ST_IDLE;
            out_state <= IO_ST_IDLE;
            io_in_q   <= '0;
            eof_seen  <= 1'b0;
        end else begin
            in_state  <= in_next;
            out_state <= out_next;
            if (rx_pop)      io_in_q  <= rx_head;
            if (bus.rx_end)  eof_seen <= 1'b1;
        end
    end

`ifdef SUBLEQ_IO_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (rx_pop)  rd_count <= rd_count + 1'b1;
            if (tx_push) wr_count <= wr_count + 1'b1;
        end
    end
`endif

    assign tx_pop       = !tx_empty && bus.tx_ready;
    assign bus.tx_valid = !tx_empty;
    assign bus.rx_ready = !rx_full;
    assign bus.in_ack   = (in_state == IO_ST_ACK);
    assign bus.out_ack  = (out_state == IO_ST_ACK);
    assign bus.io_in    = io_in_q;
    // Words queued before rx_end still drain first: eof waits for the rx FIFO to empty.
    assign bus.eof      = eof_seen && rx_empty;
endmodule

// File: tb/tb_subleq_io_port.sv
// Directed self-checking bench for subleq_io_port (handshakes, FIFO limits, eof, reset, optional stats).
module tb_subleq_io_port;
    localparam int W = 16;
    localparam int D = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    subleq_io_port_if #(.WIDTH(W)) bus ();

`ifdef SUBLEQ_IO_STATS_EN
    logic [W-1:0] rd_count;
    logic [W-1:0] wr_count;
`endif

    subleq_io_port #(.WIDTH(W), .DEPTH(D)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus)
`ifdef SUBLEQ_IO_STATS_EN
        ,
        .rd_count (rd_count),
        .wr_count (wr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic push_rx(input logic [W-1:0] v);
        bus.rx_valid = 1'b1;
        bus.rx_data  = v;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [W-1:0] exp);
        int n;
        n = 0;
        bus.in_req = 1'b1;
        while (!bus.in_ack && n < 30) begin
            tick();
            n++;
        end
        check({tag, "_ack"}, bus.in_ack, 1'b1);
        check({tag, "_data"}, bus.io_in, exp);
        bus.in_req = 1'b0;
        tick();
        check({tag, "_ack_drop"}, bus.in_ack, 1'b0);
    endtask

    task automatic do_write(input string tag, input logic [W-1:0] v);
        int n;
        n = 0;
        bus.out_req = 1'b1;
        bus.io_out  = v;
        while (!bus.out_ack && n < 30) begin
            tick();
            n++;
        end
        check({tag, "_ack"}, bus.out_ack, 1'b1);
        bus.out_req = 1'b0;
        tick();
        check({tag, "_ack_drop"}, bus.out_ack, 1'b0);
    endtask

    initial begin
        logic seen;
        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        bus.in_req   = 1'b0;
        bus.out_req  = 1'b0;
        bus.io_out   = '0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        bus.rx_end   = 1'b0;
        bus.tx_ready = 1'b0;
        tick();
        apply_reset();
        tick();

        // Reset / idle state
        check("rst_in_ack", bus.in_ack, 1'b0);
        check("rst_out_ack", bus.out_ack, 1'b0);
        check("rst_tx_valid", bus.tx_valid, 1'b0);
        check("rst_rx_ready", bus.rx_ready, 1'b1);
        check("rst_eof", bus.eof, 1'b0);
        check("rst_io_in", bus.io_in, 16'h0000);

        // Two queued words, exact 1-cycle latency on the first read
        push_rx(16'h0005);
        push_rx(16'h0007);
        bus.in_req = 1'b1;
        check("rd1_ack_before_edge", bus.in_ack, 1'b0);
        tick();
        check("rd1_ack_latency", bus.in_ack, 1'b1);
        check("rd1_data", bus.io_in, 16'h0005);
        tick();
        check("rd1_ack_held", bus.in_ack, 1'b1);
        bus.in_req = 1'b0;
        tick();
        check("rd1_ack_drop", bus.in_ack, 1'b0);
        check("rd1_data_hold", bus.io_in, 16'h0005);
        do_read("rd2", 16'h0007);

        // Read from empty rx waits until the word arrives
        bus.in_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.in_ack) seen = 1'b1;
        end
        check("empty_no_ack", seen, 1'b0);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 16'h0003;
        tick();
        bus.rx_valid = 1'b0;
        check("no_bypass_ack", bus.in_ack, 1'b0);
        tick();
        check("late_ack", bus.in_ack, 1'b1);
        check("late_data", bus.io_in, 16'h0003);
        bus.in_req = 1'b0;
        tick();
        check("late_ack_drop", bus.in_ack, 1'b0);

        // tx fills to DEPTH, fifth write stalls until one word drains
        bus.tx_ready = 1'b0;
        for (int i = 1; i <= D; i++) do_write($sformatf("wr%0d", i), W'(i));
        check("tx_valid_full", bus.tx_valid, 1'b1);
        check("tx_head_1", bus.tx_data, 16'h0001);
        bus.out_req = 1'b1;
        bus.io_out  = 16'h0005;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.out_ack) seen = 1'b1;
        end
        check("wr5_stall", seen, 1'b0);
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready = 1'b0;
        check("wr5_not_yet", bus.out_ack, 1'b0);
        tick();
        check("wr5_ack", bus.out_ack, 1'b1);
        bus.out_req = 1'b0;
        tick();
        check("wr5_ack_drop", bus.out_ack, 1'b0);
        for (int i = 2; i <= 5; i++) begin
            check($sformatf("drain_valid_%0d", i), bus.tx_valid, 1'b1);
            check($sformatf("drain_data_%0d", i), bus.tx_data, 32'(i));
            bus.tx_ready = 1'b1;
            tick();
            bus.tx_ready = 1'b0;
        end
        check("drain_empty", bus.tx_valid, 1'b0);

        // eof rises only after the last word is read; later reads never ack
        bus.rx_valid = 1'b1;
        bus.rx_data  = 16'h0009;
        bus.rx_end   = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        check("eof_pending_word", bus.eof, 1'b0);
        bus.in_req = 1'b1;
        tick();
        check("eof_last_ack", bus.in_ack, 1'b1);
        check("eof_last_data", bus.io_in, 16'h0009);
        check("eof_after_pop", bus.eof, 1'b1);
        bus.in_req = 1'b0;
        tick();
        bus.in_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.in_ack) seen = 1'b1;
        end
        check("eof_never_ack", seen, 1'b0);
        check("eof_sticky", bus.eof, 1'b1);
        bus.in_req = 1'b0;

        // Reset in the middle of an input handshake
        bus.rx_end = 1'b0;
        apply_reset();
        tick();
        check("rst2_eof_clear", bus.eof, 1'b0);
        push_rx(16'h0011);
        push_rx(16'h0022);
        do_write("pre_rst_wr", 16'h0033);
        bus.in_req = 1'b1;
        tick();
        check("mid_ack", bus.in_ack, 1'b1);
        check("mid_data", bus.io_in, 16'h0011);
        rst_n = 1'b0;
        tick();
        check("mid_rst_in_ack", bus.in_ack, 1'b0);
        check("mid_rst_io_in", bus.io_in, 16'h0000);
        check("mid_rst_tx_valid", bus.tx_valid, 1'b0);
        check("mid_rst_rx_ready", bus.rx_ready, 1'b1);
        check("mid_rst_eof", bus.eof, 1'b0);
        rst_n = 1'b1;
        tick();
        check("post_rst_no_ack", bus.in_ack, 1'b0);
        bus.rx_end = 1'b1;
        tick();
        check("post_rst_rx_empty", bus.eof, 1'b1);
        bus.in_req = 1'b0;
        bus.rx_end = 1'b0;

`ifdef SUBLEQ_IO_STATS_EN
        apply_reset();
        tick();
        bus.tx_ready = 1'b1;
        push_rx(16'h00a1);
        push_rx(16'h00a2);
        push_rx(16'h00a3);
        do_read("st_rd1", 16'h00a1);
        do_read("st_rd2", 16'h00a2);
        do_read("st_rd3", 16'h00a3);
        do_write("st_wr1", 16'h00b1);
        do_write("st_wr2", 16'h00b2);
        check("stats_rd", rd_count, 16'd3);
        check("stats_wr", wr_count, 16'd2);
        apply_reset();
        tick();
        check("stats_rd_rst", rd_count, 16'd0);
        check("stats_wr_rst", wr_count, 16'd0);
        bus.tx_ready = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
